gun_pos_accum: RTL and testbench
================================

GUN_POS_ACCUM -- requirements
Module: gun_pos_accum

Parameters
REQ-001 POS_W, default 6: width of each gun position output.
REQ-002 DIV_MAX, default 3: ticks between repeat steps while a direction is held.
REQ-003 ACCEL_RUN, default 8: repeat steps before fast mode is entered.
REQ-004 FAST_STEP, default 2: step size in fast mode.
REQ-005 DEADZONE, default 16: analog magnitude at or below which input is ignored.
REQ-006 ANA_SHIFT, default 4: arithmetic right shift applied to analog input.

Interface
REQ-007 clk_sys  in  1  sole clock; all logic is on the rising edge.
REQ-008 reset  in  1  asynchronous, active-high reset.
REQ-009 tick  in  1  level strobe (e.g. cnt_4ms); the block acts only on the rising edge it detects internally.
REQ-010 joy_left, joy_right, joy_up, joy_down  in  1 each  digital direction inputs, active-high.
REQ-011 recenter  in  1  forces both axes to the midpoint.
REQ-012 accel_en  in  1  enables fast mode.
REQ-013 analog_en  in  1  selects analog mode (1) or digital mode (0).
REQ-014 analog_x, analog_y  in  8  signed two's-complement stick values.
REQ-015 gun_h, gun_v  out  POS_W  horizontal and vertical positions.
REQ-016 moving  out  1  high while either axis is stepping.

Function
REQ-017 tick_r SHALL register tick; tick_evt = tick & ~tick_r; all position and state updates SHALL occur only on clocks where tick_evt = 1.
REQ-018 Outputs SHALL change on the same clk_sys edge that samples tick_evt high, i.e. one clock after tick rises.
REQ-019 MID = 2^(POS_W-1); MAX = 2^POS_W - 1.
REQ-020 Each axis SHALL run an independent FSM with states IDLE, HOLD and FAST, plus a div counter and a run counter.
REQ-021 Axis direction on a tick: exactly one of its two inputs high gives +1 (right/down) or -1 (left/up); both inputs high or neither gives none.
REQ-022 IDLE: on a direction, step 1 immediately, set div=0, run=0, and go to HOLD.
REQ-023 HOLD: each tick with the same direction, div++; when div reaches DIV_MAX, step 1, set div=0 and run++.
REQ-024 HOLD: if accel_en = 1 and run reaches ACCEL_RUN, go to FAST.
REQ-025 FAST: behaves as HOLD but steps FAST_STEP; if accel_en falls, return to HOLD with run=0.
REQ-026 Direction none (release, or both pressed) SHALL force IDLE with no step.
REQ-027 Reversal SHALL act as a fresh press in the same tick: step 1 in the new direction and go to HOLD with div=0, run=0.
REQ-028 Analog mode (analog_en = 1): both FSMs are held in IDLE with counters cleared.
REQ-029 Analog mode, per tick per axis: if |a| > DEADZONE, add (a >>> ANA_SHIFT); otherwise add nothing.
REQ-030 |-128| SHALL be treated as 128.
REQ-031 All sums SHALL be computed signed at POS_W+2 bits and saturated to 0..MAX; no wrap-around.
REQ-032 recenter = 1 on a tick SHALL set both axes to MID and both FSMs to IDLE, with priority over all movement.
REQ-033 recenter outside a tick SHALL be ignored.
REQ-034 moving SHALL be high when either FSM is not IDLE, or when the analog delta applied on the last tick was nonzero.
REQ-035 A mode change on analog_en SHALL take effect at the next tick.

Reset
REQ-036 reset SHALL asynchronously set gun_h = gun_v = MID, both FSMs to IDLE, div = run = 0, tick_r = 0 and moving = 0.
REQ-037 reset asserted mid-hold SHALL discard all progress; after release, the first held tick SHALL be treated as a fresh press.

Verification (POS_W=6, defaults)
REQ-038 Reset release -> gun_h = 32, gun_v = 32, moving = 0.
REQ-039 joy_right held over ticks 1..9 -> gun_h = 33 at tick 1, 34 at tick 5, 35 at tick 9; gun_h is unchanged between ticks and holding tick high does not re-trigger.
REQ-040 gun_h = 62, joy_right held -> gun_h reaches 63 and stays at 63; joy_left and joy_right together -> no change and FSM in IDLE.
REQ-041 accel_en = 1, joy_down held -> after 8 repeat steps the step becomes 2, saturating at 63; accel_en dropped -> step returns to 1.
REQ-042 analog_en = 1: analog_x = +64 -> +4 per tick; analog_x = +10 -> no move and moving = 0; analog_y = -128 -> -8 per tick, clamped at 0.
REQ-043 recenter asserted during FAST on a tick -> both axes = 32 and IDLE; reset asserted mid-hold -> 32/32, next held tick steps 1.

Source files
------------

// File: rtl/gun_pos_accum_if.sv
// Bus between the light-gun position accumulator and whatever drives it.
// The master drives the joystick, analog and tick inputs; the slave returns the gun position.
interface gun_pos_accum_if #(
    parameter int POS_W = 6
);
    logic             tick;
    logic             joy_left;
    logic             joy_right;
    logic             joy_up;
    logic             joy_down;
    logic             recenter;
    logic             accel_en;
    logic             analog_en;
    logic [7:0]       analog_x;
    logic [7:0]       analog_y;
    logic [POS_W-1:0] gun_h;
    logic [POS_W-1:0] gun_v;
    logic             moving;

    modport master (
        output tick, joy_left, joy_right, joy_up, joy_down,
               recenter, accel_en, analog_en, analog_x, analog_y,
        input  gun_h, gun_v, moving
    );

    modport slave (
        input  tick, joy_left, joy_right, joy_up, joy_down,
               recenter, accel_en, analog_en, analog_x, analog_y,
        output gun_h, gun_v, moving
    );
endinterface

// File: rtl/gun_pos_accum.sv
// Gun position accumulator: digital auto-repeat with acceleration, or analog stick integration.
// Each axis saturates to 0..2^POS_W-1, and everything advances only on the rising edge of tick.
module gun_pos_accum #(
    parameter int POS_W     = 6,
    parameter int DIV_MAX   = 3,
    parameter int ACCEL_RUN = 8,
    parameter int FAST_STEP = 2,
    parameter int DEADZONE  = 16,
    parameter int ANA_SHIFT = 4
) (
    input  logic            clk_sys,
    input  logic            reset,
    gun_pos_accum_if.slave  bus
);
    localparam int S     = POS_W + 2;
    localparam int DIV_W = (DIV_MAX < 1) ? 1 : $clog2(DIV_MAX + 1);
    localparam int RUN_W = (ACCEL_RUN < 1) ? 1 : $clog2(ACCEL_RUN + 1);
    localparam logic [POS_W-1:0]    MID   = POS_W'(1 << (POS_W - 1));
    localparam logic signed [S-1:0] MAX_S = S'((1 << POS_W) - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, FAST = 2'd2} state_t;

    typedef struct packed {
        state_t             st;
        logic [DIV_W-1:0]   div;
        logic [RUN_W-1:0]   run;
        logic signed [1:0]  dir;
    } axis_t;

    logic             tick_r;
    logic             tick_evt;
    logic [POS_W-1:0] gun_h_r, gun_v_r, gun_h_nxt, gun_v_nxt;
    logic             moving_r, moving_nxt;
    axis_t            ax_h, ax_v, ax_h_nxt, ax_v_nxt;
    logic signed [1:0]   dir_h, dir_v;
    logic signed [S-1:0] dh, dv;

    function automatic logic signed [1:0] decode_dir(input logic neg, input logic pos);
        if (pos && !neg) return 2'sb01;
        if (neg && !pos) return 2'sb11;
        return 2'sb00;
    endfunction

    function automatic logic [POS_W-1:0] sat_add(input logic [POS_W-1:0] p,
                                                 input logic signed [S-1:0] dl);
        logic signed [S-1:0] sum;
        sum = $signed({2'b00, p}) + dl;
        if (sum < 0) return '0;
        if (sum > MAX_S) return '1;
        return sum[POS_W-1:0];
    endfunction

    // Magnitude is taken at 9 bits so that -128 compares as 128 against the deadzone.
    function automatic logic signed [S-1:0] ana_delta(input logic [7:0] a);
        logic [8:0]        mag;
        logic signed [7:0] sh;
        mag = a[7] ? (9'd0 - {1'b1, a}) : {1'b0, a};
        sh  = $signed(a) >>> ANA_SHIFT;
        if (mag > 9'(DEADZONE)) return S'(sh);
        return '0;
    endfunction

    // A reversal counts as a fresh press; dropping accel_en in FAST restarts the run count.
    function automatic axis_t axis_next(input axis_t cur, input logic signed [1:0] d,
                                        input logic acc, output logic signed [S-1:0] delta);
        axis_t nxt;
        logic  dropping;
        nxt      = cur;
        delta    = '0;
        dropping = (cur.st == FAST) && !acc;
        if (d == 2'sb00) begin
            nxt = '0;
        end else if (cur.st == IDLE || d != cur.dir) begin
            nxt     = '0;
            nxt.st  = HOLD;
            nxt.dir = d;
            delta   = S'(d);
        end else begin
            if (dropping) begin
                nxt.st  = HOLD;
                nxt.run = '0;
            end
            if (cur.div == DIV_W'(DIV_MAX)) begin
                nxt.div = '0;
                if (cur.st == FAST && acc)
                    delta = d[1] ? -S'(FAST_STEP) : S'(FAST_STEP);
                else
                    delta = S'(d);
                if (!dropping && cur.run < RUN_W'(ACCEL_RUN))
                    nxt.run = cur.run + 1'b1;
            end else begin
                nxt.div = cur.div + 1'b1;
            end
            if (nxt.st == HOLD && acc && nxt.run >= RUN_W'(ACCEL_RUN))
                nxt.st = FAST;
        end
        return nxt;
    endfunction

    assign tick_evt  = bus.tick & ~tick_r;
    assign bus.gun_h  = gun_h_r;
    assign bus.gun_v  = gun_v_r;
    assign bus.moving = moving_r;

    always_comb begin
        dir_h      = decode_dir(bus.joy_left, bus.joy_right);
        dir_v      = decode_dir(bus.joy_up, bus.joy_down);
        gun_h_nxt  = gun_h_r;
        gun_v_nxt  = gun_v_r;
        ax_h_nxt   = ax_h;
        ax_v_nxt   = ax_v;
        moving_nxt = moving_r;
        dh         = '0;
        dv         = '0;
        if (bus.recenter) begin
            gun_h_nxt  = MID;
            gun_v_nxt  = MID;
            ax_h_nxt   = '0;
            ax_v_nxt   = '0;
            moving_nxt = 1'b0;
        end else if (bus.analog_en) begin
            ax_h_nxt   = '0;
            ax_v_nxt   = '0;
            dh         = ana_delta(bus.analog_x);
            dv         = ana_delta(bus.analog_y);
            gun_h_nxt  = sat_add(gun_h_r, dh);
            gun_v_nxt  = sat_add(gun_v_r, dv);
            moving_nxt = (dh != '0) || (dv != '0);
        end else begin
            ax_h_nxt   = axis_next(ax_h, dir_h, bus.accel_en, dh);
            ax_v_nxt   = axis_next(ax_v, dir_v, bus.accel_en, dv);
            gun_h_nxt  = sat_add(gun_h_r, dh);
            gun_v_nxt  = sat_add(gun_v_r, dv);
            moving_nxt = (ax_h_nxt.st != IDLE) || (ax_v_nxt.st != IDLE);
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            tick_r   <= 1'b0;
            gun_h_r  <= MID;
            gun_v_r  <= MID;
            ax_h     <= '0;
            ax_v     <= '0;
            moving_r <= 1'b0;
        end else begin
            tick_r <= bus.tick;
            if (tick_evt) begin
                gun_h_r  <= gun_h_nxt;
                gun_v_r  <= gun_v_nxt;
                ax_h     <= ax_h_nxt;
                ax_v     <= ax_v_nxt;
                moving_r <= moving_nxt;
            end
        end
    end
endmodule

// File: tb/tb_gun_pos_accum.sv
// Directed test of gun_pos_accum with default parameters (POS_W = 6, so MID = 32 and MAX = 63).
// Expected positions are worked out by hand from the repeat, acceleration and analog rules.
module tb_gun_pos_accum;
    logic clk_sys;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    gun_pos_accum_if #(.POS_W(6)) bus ();

    gun_pos_accum #(
        .POS_W(6), .DIV_MAX(3), .ACCEL_RUN(8), .FAST_STEP(2), .DEADZONE(16), .ANA_SHIFT(4)
    ) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // Raises tick for one clock; returns at the negedge after the updating posedge.
    task automatic pulse_tick();
        @(negedge clk_sys);
        bus.tick = 1'b1;
        @(negedge clk_sys);
        bus.tick = 1'b0;
    endtask

    task automatic check_pos(input string name, input int exp_h, input int exp_v);
        checks++;
        if (bus.gun_h !== 6'(exp_h) || bus.gun_v !== 6'(exp_v)) begin
            errors++;
            $display("[TB] FAIL %s got h=%0d v=%0d want h=%0d v=%0d",
                     name, bus.gun_h, bus.gun_v, exp_h, exp_v);
        end
    endtask

    task automatic check_moving(input string name, input logic exp_m);
        checks++;
        if (bus.moving !== exp_m) begin
            errors++;
            $display("[TB] FAIL %s moving got %b want %b", name, bus.moving, exp_m);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk_sys);
        check_pos("reset_hold", 32, 32);
        check_moving("reset_hold", 1'b0);
        reset = 1'b0;
        @(negedge clk_sys);
        check_pos("reset_release", 32, 32);
        check_moving("reset_release", 1'b0);
    endtask

    task automatic test_hold();
        int exp_h[9] = '{33, 33, 33, 33, 34, 34, 34, 34, 35};
        bus.joy_right = 1'b1;
        for (int t = 1; t <= 9; t++) begin
            pulse_tick();
            check_pos($sformatf("hold_t%0d", t), exp_h[t-1], 32);
            if (t == 1) begin
                check_moving("hold_t1", 1'b1);
                repeat (3) @(negedge clk_sys);
                check_pos("hold_between", 33, 32);
            end
        end
        repeat (3) pulse_tick();
        check_pos("hold_t12", 35, 32);
        @(negedge clk_sys);
        bus.tick = 1'b1;
        repeat (6) @(negedge clk_sys);
        bus.tick = 1'b0;
        check_pos("hold_long_tick", 36, 32);
        bus.joy_right = 1'b0;
        pulse_tick();
        check_pos("hold_release", 36, 32);
        check_moving("hold_release", 1'b0);
    endtask

    task automatic test_analog();
        bus.analog_en = 1'b1;
        bus.analog_x  = 8'd64;
        pulse_tick();
        check_pos("ana_x64_a", 40, 32);
        check_moving("ana_x64", 1'b1);
        pulse_tick();
        check_pos("ana_x64_b", 44, 32);
        bus.analog_x = 8'd10;
        pulse_tick();
        check_pos("ana_x10", 44, 32);
        check_moving("ana_x10", 1'b0);
        bus.analog_x = 8'd17;
        pulse_tick();
        check_pos("ana_x17", 45, 32);
        bus.analog_x = 8'hF0;
        pulse_tick();
        check_pos("ana_xm16", 45, 32);
        bus.analog_x = 8'hEF;
        pulse_tick();
        check_pos("ana_xm17", 43, 32);
        bus.analog_x = 8'd0;
        bus.analog_y = 8'h80;
        pulse_tick();
        check_pos("ana_ym128_a", 43, 24);
        repeat (3) pulse_tick();
        check_pos("ana_ym128_b", 43, 0);
        pulse_tick();
        check_pos("ana_ym128_clamp", 43, 0);
        bus.analog_y = 8'd0;
        pulse_tick();
        check_moving("ana_idle", 1'b0);
    endtask

    task automatic test_saturate();
        bus.analog_x = 8'd64;
        repeat (4) pulse_tick();
        check_pos("sat_ana_59", 59, 0);
        bus.analog_x = 8'd48;
        pulse_tick();
        check_pos("sat_ana_62", 62, 0);
        bus.analog_x  = 8'd0;
        bus.analog_en = 1'b0;
        bus.joy_right = 1'b1;
        pulse_tick();
        check_pos("sat_first", 63, 0);
        repeat (8) pulse_tick();
        check_pos("sat_held", 63, 0);
        bus.joy_left = 1'b1;
        pulse_tick();
        check_pos("sat_both", 63, 0);
        check_moving("sat_both", 1'b0);
        bus.joy_left  = 1'b0;
        bus.joy_right = 1'b0;
    endtask

    task automatic test_accel();
        int ck_t[16] = '{1, 4, 5, 33, 36, 37, 41, 45, 48, 49, 53, 57, 77, 81, 93, 97};
        int ck_v[16] = '{33, 33, 34, 41, 41, 43, 45, 47, 47, 48, 49, 50, 55, 57, 63, 63};
        bus.recenter = 1'b1;
        pulse_tick();
        bus.recenter = 1'b0;
        check_pos("accel_recenter", 32, 32);
        check_moving("accel_recenter", 1'b0);
        bus.accel_en = 1'b1;
        bus.joy_down = 1'b1;
        for (int t = 1; t <= 100; t++) begin
            if (t == 46) bus.accel_en = 1'b0;
            if (t == 57) bus.accel_en = 1'b1;
            pulse_tick();
            for (int k = 0; k < 16; k++)
                if (ck_t[k] == t) check_pos($sformatf("accel_t%0d", t), 32, ck_v[k]);
        end
        check_moving("accel_end", 1'b1);
    endtask

    task automatic test_recenter();
        @(negedge clk_sys);
        bus.recenter = 1'b1;
        @(negedge clk_sys);
        bus.recenter = 1'b0;
        repeat (2) @(negedge clk_sys);
        check_pos("recenter_no_tick", 32, 63);
        bus.recenter = 1'b1;
        pulse_tick();
        bus.recenter = 1'b0;
        check_pos("recenter_fast", 32, 32);
        check_moving("recenter_fast", 1'b0);
        pulse_tick();
        check_pos("recenter_repress", 32, 33);
        check_moving("recenter_repress", 1'b1);
        bus.joy_down = 1'b0;
        bus.accel_en = 1'b0;
        pulse_tick();
        check_pos("recenter_release", 32, 33);
    endtask

    task automatic test_back_to_back();
        bus.joy_right = 1'b1;
        pulse_tick();
        pulse_tick();
        check_pos("midhold_pre", 33, 33);
        @(negedge clk_sys);
        #2 reset = 1'b1;
        #1;
        check_pos("midhold_async", 32, 32);
        check_moving("midhold_async", 1'b0);
        @(negedge clk_sys);
        reset = 1'b0;
        pulse_tick();
        check_pos("midhold_fresh", 33, 32);
        check_moving("midhold_fresh", 1'b1);
        pulse_tick();
        check_pos("midhold_next", 33, 32);
        bus.joy_left = 1'b1;
        bus.joy_right = 1'b0;
        pulse_tick();
        check_pos("midhold_reverse", 32, 32);
        bus.joy_left = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        bus.tick      = 1'b0;
        bus.joy_left  = 1'b0;
        bus.joy_right = 1'b0;
        bus.joy_up    = 1'b0;
        bus.joy_down  = 1'b0;
        bus.recenter  = 1'b0;
        bus.accel_en  = 1'b0;
        bus.analog_en = 1'b0;
        bus.analog_x  = 8'd0;
        bus.analog_y  = 8'd0;
        test_reset();
        test_hold();
        test_analog();
        test_saturate();
        test_accel();
        test_recenter();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
